addr_segregator_pipe: RTL and testbench
=======================================

// Module: addr_segregator_pipe
// PURPOSE
//  Pipelined, parametrised successor of the processor-side address segregator; sits between CPU port and L1 cache controller.
//  Accepts rd/wr commands, splits address into tag/index/offset, queues decoded requests in a DEPTH-entry FIFO.
//  Adds ready/valid back-pressure, illegal-command detection, occupancy reporting.
// PARAMETERS
//  ADDR_WID    32  address width
//  OFFSET_WID  2   block-offset bits, address[OFFSET_WID-1:0]
//  INDEX_WID   18  index bits, directly above offset
//  TAG_WID     (localparam) ADDR_WID-INDEX_WID-OFFSET_WID, default 12; elaboration error if <1
//  DEPTH       4   FIFO entries, power of 2, >=2; PTR_WID=$clog2(DEPTH)
// PORTS
//  clk              in   1             clock, rising edge
//  rst_n            in   1             asynchronous active-low reset
//  cmd_rd           in   1             read request
//  cmd_wr           in   1             write request
//  address          in   ADDR_WID      request address
//  req_ready        out  1             FIFO can accept (not full)
//  out_valid        out  1             head entry valid
//  out_ready        in   1             consumer takes head
//  out_rd           out  1             head is read
//  out_wr           out  1             head is write
//  tag_proc         out  TAG_WID       head tag
//  index_proc       out  INDEX_WID     head index
//  blk_offset_proc  out  OFFSET_WID    head block offset
//  occupancy        out  PTR_WID+1     entries held, 0..DEPTH
//  cmd_err          out  1             sticky: rd and wr asserted together
//  err_clr          in   1             clears cmd_err
// BEHAVIOUR
//  Reset (async, rst_n=0): pointers=0, occupancy=0, out_valid=0, req_ready=1, cmd_err=0; head fields read 0.
//  push = (cmd_rd ^ cmd_wr) & req_ready; pop = out_valid & out_ready.
//  req_ready = (occupancy != DEPTH), combinational from registered count; no full-bypass.
//  Accepted request stores {rd,wr,tag,index,offset}: tag=address[ADDR_WID-1 -: TAG_WID],
//   index=address[OFFSET_WID +: INDEX_WID], offset=address[OFFSET_WID-1:0].
//  Latency: accept at edge N -> out_valid=1 after edge N; no empty bypass.
//  out_valid = (occupancy != 0); head fields read combinationally from entry[rd_ptr].
//  Head fields and out_rd/out_wr stable while out_valid & !out_ready.
//  Push+pop same cycle: both happen, occupancy unchanged; when full only pop can happen.
//  Pointers wrap modulo DEPTH; order preserved (strict FIFO).
//  cmd_rd & cmd_wr both 1: not enqueued, cmd_err=1 next edge (even if full). Neither: idle, no state change.
//  err_clr=1 clears cmd_err next edge; new error in same cycle wins (cmd_err stays 1).
//  Reset mid-operation discards all queued entries; no drain.
//  Inputs sampled only on rising clk; address ignored when no push.
// CONFIGURATION
//  ADDR_SEG_STATS_EN defined: adds outputs rd_count, wr_count (32 bits each), reset 0; +1 per accepted read/write;
//   saturate at 32'hFFFF_FFFF; illegal/dropped commands not counted.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING (defaults: ADDR_WID=32, OFFSET_WID=2, INDEX_WID=18, DEPTH=4)
//  1 cmd_rd=1, addr=32'hFFFF_0000, out_ready=1 -> next cycle out_valid=1, out_rd=1, tag=12'hFFF, index=18'h3C000, offset=0.
//  2 cmd_wr=1, addr=32'hABCD_DCBA -> out_wr=1, tag=12'hABC, index=18'h3772E, offset=2'h2.
//  3 out_ready=0, push 4 reads -> occupancy=4, req_ready=0; 5th held off; head stays at 1st address.
//  4 full, then out_ready=1 with continuous pushes -> pushes resume after first pop; 5 pops in push order; ptr wrap.
//  5 cmd_rd=cmd_wr=1, addr=32'h2333_2333 -> nothing queued, cmd_err=1 sticky; err_clr=1 -> 0; rd alone -> tag 12'h233, idx 18'h0C8CC, off 3.
//  6 rst_n low with 3 entries queued, asynchronously -> out_valid=0, occupancy=0 at once; (STATS_EN) counters=0.

Source files
------------

// File: rtl/addr_segregator_pipe_if.sv
// Request/response bundle between the CPU port, the address segregator and the L1 controller.
// ADDR_SEG_STATS_EN adds the rd_count/wr_count statistics outputs.
interface addr_segregator_pipe_if #(
  parameter int ADDR_WID   = 32,
  parameter int OFFSET_WID = 2,
  parameter int INDEX_WID  = 18,
  parameter int DEPTH      = 4
);
  localparam int TAG_WID = ADDR_WID - INDEX_WID - OFFSET_WID;
  localparam int PTR_WID = $clog2(DEPTH);

  logic                  cmd_rd;
  logic                  cmd_wr;
  logic [ADDR_WID-1:0]   address;
  logic                  req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_rd;
  logic                  out_wr;
  logic [TAG_WID-1:0]    tag_proc;
  logic [INDEX_WID-1:0]  index_proc;
  logic [OFFSET_WID-1:0] blk_offset_proc;
  logic [PTR_WID:0]      occupancy;
  logic                  cmd_err;
  logic                  err_clr;
`ifdef ADDR_SEG_STATS_EN
  logic [31:0]           rd_count;
  logic [31:0]           wr_count;
`endif

  modport slave (
`ifdef ADDR_SEG_STATS_EN
    output rd_count, wr_count,
`endif
    input  cmd_rd, cmd_wr, address, out_ready, err_clr,
    output req_ready, out_valid, out_rd, out_wr, tag_proc, index_proc,
           blk_offset_proc, occupancy, cmd_err
  );

  modport master (
`ifdef ADDR_SEG_STATS_EN
    input  rd_count, wr_count,
`endif
    output cmd_rd, cmd_wr, address, out_ready, err_clr,
    input  req_ready, out_valid, out_rd, out_wr, tag_proc, index_proc,
           blk_offset_proc, occupancy, cmd_err
  );
endinterface

// File: rtl/addr_segregator_pipe.sv
// Pipelined address segregator: splits rd/wr requests into tag/index/offset and queues them in a FIFO.
// Define ADDR_SEG_STATS_EN to add saturating accepted-read/write counters.
module addr_segregator_pipe #(
  parameter int ADDR_WID   = 32,
  parameter int OFFSET_WID = 2,
  parameter int INDEX_WID  = 18,
  parameter int DEPTH      = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  addr_segregator_pipe_if.slave bus
);
  localparam int TAG_WID   = ADDR_WID - INDEX_WID - OFFSET_WID;
  localparam int PTR_WID   = $clog2(DEPTH);
  localparam int ENTRY_WID = 2 + TAG_WID + INDEX_WID + OFFSET_WID;

  if (TAG_WID < 1) begin : g_tag_check
    $error("addr_segregator_pipe: TAG_WID must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("addr_segregator_pipe: DEPTH must be a power of 2 and >= 2");
  end

  logic [ENTRY_WID-1:0] mem [DEPTH];
  logic [PTR_WID-1:0]   wr_ptr, rd_ptr;
  logic [PTR_WID:0]     count;
  logic                 err_q;
  logic                 full, empty, push, pop, illegal;
  logic [ENTRY_WID-1:0] head;

  assign full    = (count == (PTR_WID+1)'(DEPTH));
  assign empty   = (count == '0);
  assign illegal = bus.cmd_rd & bus.cmd_wr;
  assign push    = (bus.cmd_rd ^ bus.cmd_wr) & ~full;
  assign pop     = ~empty & bus.out_ready;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {bus.cmd_rd, bus.cmd_wr,
                      bus.address[ADDR_WID-1 -: TAG_WID],
                      bus.address[OFFSET_WID +: INDEX_WID],
                      bus.address[OFFSET_WID-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WID'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WID'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_WID+1)'(1);
        2'b01:   count <= count - (PTR_WID+1)'(1);
        default: count <= count;
      endcase
      // A fresh illegal command takes priority over a clear in the same cycle.
      if (illegal)          err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  // Storage is not reset, so the head is masked to zero whenever the queue is empty.
  assign head = empty ? '0 : mem[rd_ptr];

  assign bus.req_ready       = ~full;
  assign bus.out_valid       = ~empty;
  assign bus.out_rd          = head[ENTRY_WID-1];
  assign bus.out_wr          = head[ENTRY_WID-2];
  assign bus.tag_proc        = head[OFFSET_WID+INDEX_WID +: TAG_WID];
  assign bus.index_proc      = head[OFFSET_WID +: INDEX_WID];
  assign bus.blk_offset_proc = head[OFFSET_WID-1:0];
  assign bus.occupancy       = count;
  assign bus.cmd_err         = err_q;

`ifdef ADDR_SEG_STATS_EN
  logic [31:0] rd_cnt, wr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (push && bus.cmd_rd && rd_cnt != '1) rd_cnt <= rd_cnt + 32'd1;
      if (push && bus.cmd_wr && wr_cnt != '1) wr_cnt <= wr_cnt + 32'd1;
    end
  end

  assign bus.rd_count = rd_cnt;
  assign bus.wr_count = wr_cnt;
`endif
endmodule

// File: tb/tb_addr_segregator_pipe.sv
// Directed self-checking bench for addr_segregator_pipe at default parameters.
// Honours ADDR_SEG_STATS_EN to also exercise the statistics counters.
module tb_addr_segregator_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addr_segregator_pipe_if #(.ADDR_WID(32), .OFFSET_WID(2), .INDEX_WID(18), .DEPTH(4)) bus ();

  addr_segregator_pipe #(.ADDR_WID(32), .OFFSET_WID(2), .INDEX_WID(18), .DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Inputs change 1ns after a rising edge; outputs are inspected at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_rd = 1'b0; bus.cmd_wr = 1'b0; bus.address = '0;
    bus.out_ready = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.cmd_err !== 1'b0) begin failures++; $display("FAIL reset_cmd_err got=%b exp=0", bus.cmd_err); end
    checks++; if ({bus.out_rd, bus.out_wr, bus.tag_proc, bus.index_proc, bus.blk_offset_proc} !== 34'd0) begin
      failures++; $display("FAIL reset_head got=%h exp=0", {bus.out_rd, bus.out_wr, bus.tag_proc, bus.index_proc, bus.blk_offset_proc}); end
  endtask

  task automatic test_read_decode();
    bus.cmd_rd = 1'b1; bus.address = 32'hFFFF_0000; bus.out_ready = 1'b1;
    tick();
    bus.cmd_rd = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rd_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_rd !== 1'b1 || bus.out_wr !== 1'b0) begin failures++; $display("FAIL rd_kind got=%b%b exp=10", bus.out_rd, bus.out_wr); end
    checks++; if (bus.tag_proc !== 12'hFFF) begin failures++; $display("FAIL rd_tag got=%h exp=fff", bus.tag_proc); end
    checks++; if (bus.index_proc !== 18'h3C000) begin failures++; $display("FAIL rd_index got=%h exp=3c000", bus.index_proc); end
    checks++; if (bus.blk_offset_proc !== 2'h0) begin failures++; $display("FAIL rd_offset got=%h exp=0", bus.blk_offset_proc); end
    checks++; if (bus.occupancy !== 3'd1) begin failures++; $display("FAIL rd_occupancy got=%0d exp=1", bus.occupancy); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rd_drained got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_write_decode();
    bus.cmd_wr = 1'b1; bus.address = 32'hABCD_DCBA; bus.out_ready = 1'b1;
    tick();
    bus.cmd_wr = 1'b0;
    checks++; if (bus.out_wr !== 1'b1 || bus.out_rd !== 1'b0) begin failures++; $display("FAIL wr_kind got=%b%b exp=01", bus.out_rd, bus.out_wr); end
    checks++; if (bus.tag_proc !== 12'hABC) begin failures++; $display("FAIL wr_tag got=%h exp=abc", bus.tag_proc); end
    checks++; if (bus.index_proc !== 18'h3772E) begin failures++; $display("FAIL wr_index got=%h exp=3772e", bus.index_proc); end
    checks++; if (bus.blk_offset_proc !== 2'h2) begin failures++; $display("FAIL wr_offset got=%h exp=2", bus.blk_offset_proc); end
    tick();
    checks++; if (bus.occupancy !== 3'd0) begin failures++; $display("FAIL wr_drained got=%0d exp=0", bus.occupancy); end
  endtask

  // Addresses with distinct tags/offsets so FIFO order is visible at the head.
  logic [31:0] addrs [5] = '{32'h1111_1111, 32'h2222_2226, 32'h3333_333B, 32'h4444_444C, 32'h5555_5551};
  logic [11:0] tags  [5] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
  logic [1:0]  offs  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  task automatic test_fill_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_rd = 1'b1; bus.address = addrs[i];
      tick();
    end
    checks++; if (bus.occupancy !== 3'd4) begin failures++; $display("FAIL full_occupancy got=%0d exp=4", bus.occupancy); end
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL full_req_ready got=%b exp=0", bus.req_ready); end
    bus.address = addrs[4];
    tick(); tick();
    checks++; if (bus.occupancy !== 3'd4) begin failures++; $display("FAIL full_held_occupancy got=%0d exp=4", bus.occupancy); end
    checks++; if (bus.tag_proc !== tags[0] || bus.blk_offset_proc !== offs[0] || bus.index_proc !== 18'h04444) begin
      failures++; $display("FAIL full_head got=%h/%h/%h exp=111/04444/1", bus.tag_proc, bus.index_proc, bus.blk_offset_proc); end
  endtask

  task automatic test_drain_wrap();
    int exp_occ [5] = '{3, 3, 2, 1, 0};
    bus.out_ready = 1'b1;   // cmd_rd still high with addrs[4]
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.tag_proc !== tags[k] || bus.blk_offset_proc !== offs[k] || bus.out_rd !== 1'b1) begin
        failures++; $display("FAIL drain_head%0d got=%h/%h exp=%h/%h", k, bus.tag_proc, bus.blk_offset_proc, tags[k], offs[k]); end
      tick();
      if (k == 1) bus.cmd_rd = 1'b0;
      checks++; if (bus.occupancy !== 3'(exp_occ[k])) begin
        failures++; $display("FAIL drain_occ%0d got=%0d exp=%0d", k, bus.occupancy, exp_occ[k]); end
    end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_cmd_err();
    bus.cmd_rd = 1'b1; bus.cmd_wr = 1'b1; bus.address = 32'h2333_2333; bus.out_ready = 1'b1;
    tick();
    bus.cmd_rd = 1'b0; bus.cmd_wr = 1'b0;
    checks++; if (bus.cmd_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", bus.cmd_err); end
    checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin failures++; $display("FAIL err_not_queued got=%b/%0d exp=0/0", bus.out_valid, bus.occupancy); end
    tick();
    checks++; if (bus.cmd_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus.cmd_err); end
    bus.err_clr = 1'b1; bus.cmd_rd = 1'b1; bus.cmd_wr = 1'b1;
    tick();
    checks++; if (bus.cmd_err !== 1'b1) begin failures++; $display("FAIL err_priority got=%b exp=1", bus.cmd_err); end
    bus.cmd_rd = 1'b0; bus.cmd_wr = 1'b0;
    tick();
    bus.err_clr = 1'b0;
    checks++; if (bus.cmd_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", bus.cmd_err); end
    bus.cmd_rd = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.cmd_rd = 1'b0;
    checks++; if (bus.tag_proc !== 12'h233 || bus.index_proc !== 18'h0C8CC || bus.blk_offset_proc !== 2'h3) begin
      failures++; $display("FAIL err_then_rd got=%h/%h/%h exp=233/0c8cc/3", bus.tag_proc, bus.index_proc, bus.blk_offset_proc); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0; bus.cmd_wr = 1'b1; bus.address = 32'h0000_0004;
    tick(); tick();
    bus.cmd_wr = 1'b0;
    checks++; if (bus.occupancy !== 3'd3) begin failures++; $display("FAIL pre_reset_occ got=%0d exp=3", bus.occupancy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL async_reset got=%b/%0d/%b exp=0/0/1", bus.out_valid, bus.occupancy, bus.req_ready); end
`ifdef ADDR_SEG_STATS_EN
    checks++; if (bus.rd_count !== 32'd0 || bus.wr_count !== 32'd0) begin
      failures++; $display("FAIL async_reset_counts got=%0d/%0d exp=0/0", bus.rd_count, bus.wr_count); end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef ADDR_SEG_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin   // fifth read is dropped while full
      bus.cmd_rd = 1'b1; bus.address = addrs[i];
      tick();
    end
    bus.cmd_wr = 1'b1;                   // illegal pair, not counted
    tick();
    bus.cmd_rd = 1'b0; bus.out_ready = 1'b1;   // write blocked this cycle, then accepted
    tick(); tick();
    bus.cmd_wr = 1'b0;
    checks++; if (bus.rd_count !== 32'd4) begin failures++; $display("FAIL stats_rd got=%0d exp=4", bus.rd_count); end
    checks++; if (bus.wr_count !== 32'd1) begin failures++; $display("FAIL stats_wr got=%0d exp=1", bus.wr_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_decode();
    test_write_decode();
    test_fill_backpressure();
    test_drain_wrap();
    test_cmd_err();
    test_async_reset();
`ifdef ADDR_SEG_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
